// File: rtl/sram_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bist_pkg
//  Description : Shared state encoding, March C- element table and data
//                backgrounds for the SRAM BIST controller.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_bist_pkg;

    // Controller states; M0..M5 are consecutive so the element index is
    // simply the state minus c_ST_M0.
    localparam logic [3:0] c_ST_IDLE  = 4'd0;
    localparam logic [3:0] c_ST_M0    = 4'd1;
    localparam logic [3:0] c_ST_M1    = 4'd2;
    localparam logic [3:0] c_ST_M2    = 4'd3;
    localparam logic [3:0] c_ST_M3    = 4'd4;
    localparam logic [3:0] c_ST_M4    = 4'd5;
    localparam logic [3:0] c_ST_M5    = 4'd6;
    localparam logic [3:0] c_ST_FLUSH = 4'd7;
    localparam logic [3:0] c_ST_DONE  = 4'd8;

    localparam logic [2:0] c_LAST_ELEM = 3'd5;

    // Per-element attributes, bit i describes march element Mi.
    //   M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 dn r0,w1 | M4 dn r1,w0 | M5 up r0
    localparam logic [5:0] c_ELEM_DESC      = 6'b011000;
    localparam logic [5:0] c_ELEM_HAS_READ  = 6'b111110;
    localparam logic [5:0] c_ELEM_HAS_WRITE = 6'b011111;
    localparam logic [5:0] c_ELEM_RD_ONES   = 6'b010100;
    localparam logic [5:0] c_ELEM_WR_ONES   = 6'b001010;

    // Data backgrounds for one SRAM byte.
    localparam logic [7:0] c_D0 = 8'h00;
    localparam logic [7:0] c_D1 = 8'hFF;

    // Element index of a march state.
    function automatic logic [2:0] elem_of(input logic [3:0] st);
        logic [3:0] w_diff;
        w_diff = st - c_ST_M0;
        return w_diff[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bist_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bist_addr_gen
//  Description : Loadable up/down word-address counter with an op-phase
//                toggle for read-then-write march elements and a terminal
//                count flag that marks the final op of an element.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_bist_addr_gen #(
    parameter int SRAM_ADDR_WIDTH = 13
) (
    input  wire logic                       hclk,
    input  wire logic                       hresetn,
    input  wire logic                       i_load,
    input  wire logic                       i_desc,
    input  wire logic                       i_two_op,
    input  wire logic                       i_step,
    output logic [SRAM_ADDR_WIDTH-1:0]      o_addr,
    output logic                            o_phase,
    output logic                            o_tc,
    output logic                            o_last
);

    localparam logic [SRAM_ADDR_WIDTH-1:0] c_ONE = {{(SRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [SRAM_ADDR_WIDTH-1:0] r_addr;
    logic                       r_phase;
    logic                       r_desc;

    // Load the element start address, otherwise step: a two-op element
    // holds the address for its write phase before advancing.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_addr  <= '0;
            r_phase <= 1'b0;
            r_desc  <= 1'b0;
        end else if (i_load) begin
            r_addr  <= i_desc ? '1 : '0;
            r_phase <= 1'b0;
            r_desc  <= i_desc;
        end else if (i_step) begin
            if (i_two_op && !r_phase) begin
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                r_addr  <= r_desc ? (r_addr - c_ONE) : (r_addr + c_ONE);
            end
        end
    end

    assign o_addr  = r_addr;
    assign o_phase = r_phase;
    assign o_tc    = r_desc ? (r_addr == '0) : (r_addr == '1);
    assign o_last  = o_tc && (r_phase || !i_two_op);

endmodule
`default_nettype wire

// File: rtl/sram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bist_ctrl
//  Description : March C- BIST controller for the 2-bank 8 x SRAM array.
//                Passes the functional interface through when idle; when a
//                run is active it owns the array, checks read-back data one
//                cycle after each read and records the first failure.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_DATA_WIDTH = 8
) (
    input  wire logic                       hclk,
    input  wire logic                       hresetn,
    input  wire logic                       bist_start,
    input  wire logic [SRAM_ADDR_WIDTH-1:0] f_sram_addr,
    input  wire logic [DATA_WIDTH-1:0]      f_sram_wdata,
    input  wire logic                       f_sram_we,
    input  wire logic [3:0]                 f_bank0_cs,
    input  wire logic [3:0]                 f_bank1_cs,
    input  wire logic [SRAM_DATA_WIDTH-1:0] sram_b0,
    input  wire logic [SRAM_DATA_WIDTH-1:0] sram_b1,
    input  wire logic [SRAM_DATA_WIDTH-1:0] sram_b2,
    input  wire logic [SRAM_DATA_WIDTH-1:0] sram_b3,
    input  wire logic [SRAM_DATA_WIDTH-1:0] sram_b4,
    input  wire logic [SRAM_DATA_WIDTH-1:0] sram_b5,
    input  wire logic [SRAM_DATA_WIDTH-1:0] sram_b6,
    input  wire logic [SRAM_DATA_WIDTH-1:0] sram_b7,
    output logic [SRAM_ADDR_WIDTH-1:0]      sram_addr,
    output logic [DATA_WIDTH-1:0]           sram_wdata,
    output logic                            sram_we,
    output logic [3:0]                      bank0_cs,
    output logic [3:0]                      bank1_cs,
    output logic                            bist_busy,
    output logic                            bist_done,
    output logic                            bist_fail,
    output logic [SRAM_ADDR_WIDTH-1:0]      fail_addr,
    output logic [2:0]                      fail_elem,
    output logic [7:0]                      fail_mask
);

    localparam int c_REPL = DATA_WIDTH / SRAM_DATA_WIDTH;

    logic [3:0]                 r_state;
    logic [3:0]                 w_state_nxt;
    logic                       w_march;
    logic                       w_start;
    logic [2:0]                 w_elem;
    logic [2:0]                 w_next_elem;
    logic                       w_has_read;
    logic                       w_has_write;
    logic                       w_two_op;
    logic                       w_op_write;
    logic                       w_op_read;
    logic [SRAM_DATA_WIDTH-1:0] w_wbyte;
    logic [SRAM_ADDR_WIDTH-1:0] w_gen_addr;
    logic                       w_phase;
    logic                       w_tc;
    logic                       w_last;
    logic                       w_load;
    logic                       w_load_desc;
    logic [SRAM_DATA_WIDTH-1:0] w_rd [8];
    logic [7:0]                 w_mask;

    logic                       r_cmp_valid;
    logic [SRAM_DATA_WIDTH-1:0] r_cmp_exp;
    logic [SRAM_ADDR_WIDTH-1:0] r_cmp_addr;
    logic [2:0]                 r_cmp_elem;
    logic                       r_done;
    logic                       r_fail;
    logic [SRAM_ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]                 r_fail_elem;
    logic [7:0]                 r_fail_mask;

    assign w_march     = (r_state >= c_ST_M0) && (r_state <= c_ST_M5);
    assign w_start     = ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE)) && bist_start;
    assign w_elem      = elem_of(r_state);
    assign w_next_elem = w_elem + 3'd1;
    assign w_has_read  = c_ELEM_HAS_READ[w_elem];
    assign w_has_write = c_ELEM_HAS_WRITE[w_elem];
    assign w_two_op    = w_has_read && w_has_write;
    assign w_op_write  = w_march && w_has_write && (!w_has_read || w_phase);
    assign w_op_read   = w_march && !w_op_write;
    assign w_wbyte     = c_ELEM_WR_ONES[w_elem] ? c_D1 : c_D0;

    // Counter is reloaded on start and on the last op of every element but M5.
    assign w_load      = w_start || (w_march && w_last && (w_elem != c_LAST_ELEM));
    assign w_load_desc = w_start ? c_ELEM_DESC[0] : c_ELEM_DESC[w_next_elem];

    sram_bist_addr_gen #(
        .SRAM_ADDR_WIDTH (SRAM_ADDR_WIDTH)
    ) u_addr_gen (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .i_load   (w_load),
        .i_desc   (w_load_desc),
        .i_two_op (w_two_op),
        .i_step   (w_march),
        .o_addr   (w_gen_addr),
        .o_phase  (w_phase),
        .o_tc     (w_tc),
        .o_last   (w_last)
    );

    // Next-state: walk M0..M5 on element completion, then one flush cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_ST_M0;
        end else if (w_march && w_last) begin
            w_state_nxt = r_state + 4'd1;
        end else if (r_state == c_ST_FLUSH) begin
            w_state_nxt = c_ST_DONE;
        end
    end

    // State register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Array mux: BIST owns the array from M0 through FLUSH.
    always_comb begin
        sram_addr  = f_sram_addr;
        sram_wdata = f_sram_wdata;
        sram_we    = f_sram_we;
        bank0_cs   = f_bank0_cs;
        bank1_cs   = f_bank1_cs;
        if (bist_busy) begin
            sram_addr  = w_gen_addr;
            sram_wdata = w_op_write ? {c_REPL{w_wbyte}} : '0;
            sram_we    = w_op_write;
            bank0_cs   = w_march ? 4'b1111 : 4'b0000;
            bank1_cs   = w_march ? 4'b1111 : 4'b0000;
        end
    end

    assign w_rd[0] = sram_b0;
    assign w_rd[1] = sram_b1;
    assign w_rd[2] = sram_b2;
    assign w_rd[3] = sram_b3;
    assign w_rd[4] = sram_b4;
    assign w_rd[5] = sram_b5;
    assign w_rd[6] = sram_b6;
    assign w_rd[7] = sram_b7;

    // Per-SRAM mismatch against the byte expected for last cycle's read.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_mask[i] = r_cmp_valid && (w_rd[i] != r_cmp_exp);
        end
    end

    // Compare pipeline, first-failure capture and completion flag.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_mask <= '0;
        end else if (w_start) begin
            r_cmp_valid <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_mask <= '0;
        end else begin
            r_cmp_valid <= w_op_read;
            r_cmp_exp   <= c_ELEM_RD_ONES[w_elem] ? c_D1 : c_D0;
            r_cmp_addr  <= w_gen_addr;
            r_cmp_elem  <= w_elem;
            if ((|w_mask) && !r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_cmp_addr;
                r_fail_elem <= r_cmp_elem;
                r_fail_mask <= w_mask;
            end
            if (r_state == c_ST_FLUSH) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bist_busy = w_march || (r_state == c_ST_FLUSH);
    assign bist_done = r_done;
    assign bist_fail = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;
    assign fail_mask = r_fail_mask;

endmodule
`default_nettype wire
